// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, per-button stability-count debounce,
// one-cycle press pulses and a highest-index keycode/strobe encoder.
module pb_conditioner #(
    parameter int WIDTH    = 21,
    parameter int DEBOUNCE = 3
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb,
    output logic [WIDTH-1:0] pb_clean,
    output logic [WIDTH-1:0] pb_press,
    output logic [4:0]       key_code,
    output logic             key_strobe
);

    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [4:0]       code_nxt;

    // NOTE: every output of this block gets a default before any branch, so no latches form.
    always_comb begin
        clean_nxt = pb_clean;
        code_nxt  = key_code;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != pb_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise = clean_nxt & ~pb_clean;
        // Ascending scan: the highest newly pressed index overwrites lower ones.
        for (int i = 0; i < WIDTH; i++) begin
            if (rise[i]) begin
                code_nxt = 5'(i);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            pb_clean   <= '0;
            pb_press   <= '0;
            key_code   <= '0;
            key_strobe <= 1'b0;
            // NOTE: the counter array is reset too, so a count in progress never survives reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= pb;
            s2         <= s1;
            pb_clean   <= clean_nxt;
            pb_press   <= rise;
            key_code   <= code_nxt;
            key_strobe <= |rise;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner: default build plus a DEBOUNCE=1 build, hand-computed expectations.
module tb_pb_conditioner;

    logic        hz100;
    logic        reset;
    logic [20:0] pb, pb_clean, pb_press;
    logic [4:0]  key_code;
    logic        key_strobe;
    logic [20:0] pb2, pb_clean2, pb_press2;
    logic [4:0]  key_code2;
    logic        key_strobe2;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int press_cnt  [21];
    int press_cnt2 [21];
    int s0;

    pb_conditioner #(.WIDTH(21), .DEBOUNCE(3)) dut (
        .hz100(hz100), .reset(reset), .pb(pb),
        .pb_clean(pb_clean), .pb_press(pb_press),
        .key_code(key_code), .key_strobe(key_strobe)
    );

    pb_conditioner #(.WIDTH(21), .DEBOUNCE(1)) dut1 (
        .hz100(hz100), .reset(reset), .pb(pb2),
        .pb_clean(pb_clean2), .pb_press(pb_press2),
        .key_code(key_code2), .key_strobe(key_strobe2)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    initial begin
        for (int i = 0; i < 21; i++) begin
            press_cnt[i]  = 0;
            press_cnt2[i] = 0;
        end
    end

    always @(negedge hz100) begin
        if (key_strobe) strobe_cnt <= strobe_cnt + 1;
        for (int i = 0; i < 21; i++) begin
            if (pb_press[i])  press_cnt[i]  <= press_cnt[i] + 1;
            if (pb_press2[i]) press_cnt2[i] <= press_cnt2[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hz100);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pb    = '0;
        pb2   = '0;
        step(2);
        check("rst_clean",  pb_clean,   0);
        check("rst_press",  pb_press,   0);
        check("rst_code",   key_code,   0);
        check("rst_strobe", key_strobe, 0);
        reset = 1'b0;
        step(2);

        // Clean press/release on pb[5]
        pb[5] = 1'b1;
        step(4);
        check("p5_clean_e3", pb_clean[5], 0);
        step(1);
        check("p5_clean_e4",  pb_clean[5],  1);
        check("p5_press_e4",  pb_press,     21'h20);
        check("p5_strobe_e4", key_strobe,   1);
        check("p5_code_e4",   key_code,     5);
        step(1);
        check("p5_press_e5",  pb_press,     0);
        check("p5_strobe_e5", key_strobe,   0);
        check("p5_code_e5",   key_code,     5);
        step(4);
        pb[5] = 1'b0;
        step(4);
        check("r5_clean_e3", pb_clean[5], 1);
        step(1);
        check("r5_clean_e4",  pb_clean[5], 0);
        check("r5_press_e4",  pb_press,    0);
        check("r5_strobe_e4", key_strobe,  0);
        check("r5_code_held", key_code,    5);
        check("p5_strobes",   strobe_cnt,  1);

        // Bounce rejection on pb[0]: 1,1,0,1,1,0
        pb[0] = 1'b1; step(2);
        pb[0] = 1'b0; step(1);
        pb[0] = 1'b1; step(2);
        pb[0] = 1'b0; step(1);
        step(6);
        check("b0_clean",   pb_clean[0],  0);
        check("b0_presses", press_cnt[0], 0);
        check("b0_strobes", strobe_cnt,   1);
        pb[0] = 1'b1;
        step(4);
        check("b0_hold_e3", pb_clean[0], 0);
        step(1);
        check("b0_hold_e4",   pb_clean[0], 1);
        check("b0_press_e4",  pb_press,    21'h1);
        check("b0_code_e4",   key_code,    0);
        check("b0_strobe_e4", key_strobe,  1);
        pb[0] = 1'b0;
        step(6);

        // Simultaneous press of 3, 9, 17
        s0 = strobe_cnt;
        pb = 21'h20208;
        step(4);
        check("sim_clean_e3", pb_clean, 0);
        step(1);
        check("sim_press",  pb_press,   21'h20208);
        check("sim_clean",  pb_clean,   21'h20208);
        check("sim_strobe", key_strobe, 1);
        check("sim_code",   key_code,   17);
        step(1);
        check("sim_press_off", pb_press, 0);
        check("sim_strobes",   strobe_cnt - s0, 1);
        pb = '0;
        step(6);

        // Staggered: hold 20, press 2 six cycles later
        s0 = strobe_cnt;
        pb[20] = 1'b1;
        step(5);
        check("stg_strobe20", key_strobe, 1);
        check("stg_code20",   key_code,   20);
        step(1);
        pb[2] = 1'b1;
        step(5);
        check("stg_strobe2", key_strobe,   1);
        check("stg_code2",   key_code,     2);
        check("stg_press2",  pb_press,     21'h4);
        check("stg_hold20",  pb_clean[20], 1);
        pb[2] = 1'b0;
        step(6);
        check("stg_clean_end", pb_clean,        21'h100000);
        check("stg_strobes",   strobe_cnt - s0, 2);

        // Async reset mid-count on pb[7]; pb[20] is still held
        pb[7] = 1'b1;
        step(4);
        #3;
        reset = 1'b1;
        #1;
        check("ar_clean",  pb_clean,   0);
        check("ar_press",  pb_press,   0);
        check("ar_code",   key_code,   0);
        check("ar_strobe", key_strobe, 0);
        repeat (2) @(posedge hz100);
        #1;
        reset = 1'b0;
        s0 = strobe_cnt;
        step(4);
        check("ar_clean_e3", pb_clean, 0);
        step(1);
        check("ar_clean_e4",  pb_clean,   21'h100080);
        check("ar_press_e4",  pb_press,   21'h100080);
        check("ar_strobe_e4", key_strobe, 1);
        check("ar_code_e4",   key_code,   20);
        step(1);
        check("ar_press_off", pb_press,        0);
        check("ar_strobes",   strobe_cnt - s0, 1);
        pb = '0;

        // DEBOUNCE=1 build: one-cycle press on pb2[1]
        pb2[1] = 1'b1;
        step(1);
        pb2[1] = 1'b0;
        step(1);
        check("d1_clean_e1", pb_clean2[1], 0);
        step(1);
        check("d1_clean_e2",  pb_clean2[1], 1);
        check("d1_press_e2",  pb_press2,    21'h2);
        check("d1_strobe_e2", key_strobe2,  1);
        check("d1_code_e2",   key_code2,    1);
        step(1);
        check("d1_clean_e3", pb_clean2[1], 0);
        check("d1_press_e3", pb_press2,    0);
        step(3);
        check("d1_presses", press_cnt2[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
